// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side drain stage.
//   DATA_WIDTH   default FIFO word width
//   SKID_DEPTH   entries in the output buffer that absorbs the FIFO read latency
//   word_t       one FIFO word at the default width
//   skid_occupancy()  buffer occupancy one cycle ahead, used to throttle reads
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int SKID_DEPTH = 2;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Entries the buffer will hold after this edge: the current entries, plus
  // the word already returning from the FIFO, minus the word leaving now.
  function automatic logic [2:0] skid_occupancy(input logic [1:0] count,
                                                input logic       inflight,
                                                input logic       pop);
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read port and the outgoing valid/ready stream.
//   fifo_empty/fifo_data/fifo_rd_en  FIFO read side (data returns one cycle after a read)
//   out_data/out_valid/out_ready/out_last  downstream stream with packet marker
// The master modport is the drain stage's view; slave is the FIFO plus the sink.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last
  );

endinterface

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry output buffer that soaks up the FIFO's one-cycle read latency.
//   clk_rd, rst_n  read clock, synchronous active-low reset
//   flush_i        drop all held entries
//   cap_i          cap_data_i is written into the buffer this cycle
//   pop_i          head entry is consumed this cycle
//   head_o         head entry (oldest word)
//   valid_o        buffer holds at least one word
//   count_o        number of held entries, 0..2
module rd_skid_buf #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk_rd,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  cap_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic [1:0]            count_o
);
  import fifo_pkg::*;

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;   // head
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;   // tail
  logic [1:0]            count_q, count_d;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({cap_i, pop_i})
        2'b10: begin
          // Capture lands in the first free slot; the issue throttle
          // guarantees a free slot exists.
          if (count_q == 2'd0) ent0_d = cap_data_i;
          else                 ent1_d = cap_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Shift and refill: the tail moves up and the new word goes behind
          // it, or straight to the head when it was the only entry.
          if (count_q == 2'(SKID_DEPTH)) begin
            ent0_d = ent1_q;
            ent1_d = cap_data_i;
          end else begin
            ent0_d = cap_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_rd) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = ent0_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind the async FIFO. Issues FIFO reads, buffers the
// returning words in a 2-entry skid buffer, and presents them as a
// valid/ready stream framed into PKT_LEN-beat packets.
//   clk_rd   read-domain clock
//   rst_n    synchronous active-low reset
//   flush    clear buffer, in-flight word and framing (pkt_cnt kept)
//   pkt_cnt  completed packets, wraps
//   bus      FIFO read port and output stream (master view)
module fifo_rd_stream #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PKT_LEN    = 16,
  parameter int CNT_W      = 8
) (
  input  logic              clk_rd,
  input  logic              rst_n,
  input  logic              flush,
  output logic [CNT_W-1:0]  pkt_cnt,
  fifo_rd_stream_if.master  bus
);
  import fifo_pkg::*;

  logic                  pop;
  logic                  issue;
  logic                  cap;
  logic                  last;
  logic                  head_vld;
  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            count;
  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [CNT_W-1:0]      pkt_q, pkt_d;

  assign pop  = head_vld && bus.out_ready;
  assign last = head_vld && (beat_q == CNT_W'(PKT_LEN - 1));

  // Read only when the word it returns is guaranteed a slot. Held low during
  // reset so a reset cycle never pulls a word out of the FIFO that would then
  // be thrown away.
  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && !flush &&
                          (skid_occupancy(count, inflight_q, pop) < 3'(SKID_DEPTH));
  assign issue = bus.fifo_rd_en && !bus.fifo_empty;

  // A word returning during a flush belongs to the discarded stream.
  assign cap        = inflight_q && !flush;
  assign inflight_d = issue;

  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (flush) begin
      beat_d = '0;
    end else if (pop) begin
      if (last) begin
        beat_d = '0;
        pkt_d  = pkt_q + CNT_W'(1);
      end else begin
        beat_d = beat_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_rd) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      pkt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_rd     (clk_rd),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .cap_i      (cap),
    .cap_data_i (bus.fifo_data),
    .pop_i      (pop),
    .head_o     (head_data),
    .valid_o    (head_vld),
    .count_o    (count)
  );

  assign bus.out_data  = head_data;
  assign bus.out_valid = head_vld;
  assign bus.out_last  = last;
  assign pkt_cnt       = pkt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int PKT = 16;
  localparam int CW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic [CW-1:0] pkt_cnt;
  logic          rst2_n;
  logic          flush2;
  logic [CW-1:0] pkt_cnt2;

  fifo_rd_stream_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();
  fifo_rd_stream_if #(.DATA_WIDTH(DATA_WIDTH)) bus2 ();

  fifo_rd_stream #(.DATA_WIDTH(DATA_WIDTH), .PKT_LEN(PKT), .CNT_W(CW)) dut (
    .clk_rd(clk), .rst_n(rst_n), .flush(flush), .pkt_cnt(pkt_cnt), .bus(bus));

  fifo_rd_stream #(.DATA_WIDTH(DATA_WIDTH), .PKT_LEN(1), .CNT_W(CW)) dut1 (
    .clk_rd(clk), .rst_n(rst2_n), .flush(flush2), .pkt_cnt(pkt_cnt2), .bus(bus2));

  int checks   = 0;
  int failures = 0;
  logic done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- FIFO model for the main DUT ----------------
  word_t fifo_q[$];
  word_t exp_q[$];
  int    preload_req = 0, preload_done = 0, preload_len = 0, preload_base = 0;
  int    src_total = 0, src_made = 0, src_gap = 0;

  always @(posedge clk) begin
    word_t w;
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      w = fifo_q.pop_front();
      bus.fifo_data <= w;
      exp_q.push_back(w);          // every word read must appear downstream, in order
    end
    if (preload_req != preload_done) begin
      for (int i = 0; i < preload_len; i++) fifo_q.push_back(word_t'(preload_base + i));
      preload_done = preload_req;
    end
    if (src_made < src_total && $urandom_range(99) >= src_gap) begin
      fifo_q.push_back(word_t'($urandom));
      src_made++;
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- scoreboard monitor ----------------
  int        mbeat = 0;
  logic [CW-1:0] mpkt = '0;
  int        npop = 0;
  logic      prev_stall = 1'b0;
  word_t     prev_data;

  always @(negedge clk) begin
    word_t e;
    chk("pkt_cnt", 32'(pkt_cnt), 32'(mpkt));
    if (!rst_n) begin
      exp_q.delete(); mbeat = 0; mpkt = '0; prev_stall = 1'b0;
    end else if (flush) begin
      exp_q.delete(); mbeat = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid) begin
        chk("last", 32'(bus.out_last), 32'(mbeat == PKT - 1));
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty: got word 0x%0h, required no output", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", 32'(bus.out_data), 32'(e));
          end
          npop++;
          if (mbeat == PKT - 1) begin mbeat = 0; mpkt = mpkt + 1'b1; end
          else mbeat++;
        end
      end
      if (dut.u_skid.count_q == 2'd2 && !bus.out_ready)
        chk("rd_en_full", 32'(bus.fifo_rd_en), 32'd0);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // ---------------- PKT_LEN=1 instance: source, driver, monitor ----------------
  logic [7:0] src2 = 8'd0;
  logic [7:0] exp2 = 8'd0;
  logic [CW-1:0] mpkt2 = '0;
  int np2 = 0;

  always @(posedge clk) begin
    if (bus2.fifo_rd_en && !bus2.fifo_empty) begin
      bus2.fifo_data <= src2;
      src2 <= src2 + 8'd1;
    end
  end

  initial begin
    rst2_n = 1'b0; flush2 = 1'b0; bus2.out_ready = 1'b0; bus2.fifo_empty = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst2_n = 1'b1;
    while (!done) begin
      bus2.out_ready  = 1'($urandom_range(1));
      bus2.fifo_empty = ($urandom_range(3) == 0);
      tick();
    end
  end

  always @(negedge clk) begin
    if (rst2_n) begin
      chk("p1_pkt_cnt", 32'(pkt_cnt2), 32'(mpkt2));
      if (bus2.out_valid) begin
        chk("p1_last", 32'(bus2.out_last), 32'd1);
        if (bus2.out_ready) begin
          chk("p1_data", 32'(bus2.out_data), 32'(exp2));
          exp2 = exp2 + 8'd1;
          mpkt2 = mpkt2 + 1'b1;
          np2++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_valid(input string nm, input int max);
    int n = 0;
    while (!bus.out_valid && n < max) begin tick(); n++; end
    chk(nm, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    bus.out_ready = 1'b1;
    while ((bus.out_valid || !bus.fifo_empty || exp_q.size() != 0) && n < 300) begin
      tick(); n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic preload(input int base, input int len);
    preload_base = base;
    preload_len  = len;
    preload_req++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int d, start, cyc, pk;
    rst_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_count", 32'(dut.u_skid.count_q), 32'd0);
    chk("rst_beat", 32'(dut.beat_q), 32'd0);
    tick();
    rst_n = 1'b1;

    // Steady stream: 32 words preloaded, ready held high.
    bus.out_ready = 1'b1;
    preload(0, 32);
    tick();                               // cycle N: fifo_empty has fallen
    chk("lat_n0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);                       // cycle N+1
    chk("lat_n1", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("steady_valid", 32'(bus.out_valid), 32'd1);
      chk("steady_data", 32'(bus.out_data), 32'(i));
      chk("steady_last", 32'(bus.out_last), 32'((i % 16) == 15));
    end
    @(negedge clk);
    chk("steady_pkt", 32'(pkt_cnt), 32'd2);
    chk("steady_empty", 32'(bus.out_valid), 32'd0);

    // Backpressure: stall 5 cycles mid-stream.
    tick();
    start = npop;
    preload(8'h40, 20);
    wait_valid("bp_first", 20);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("bp_count", 32'(dut.u_skid.count_q), 32'd2);
    chk("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    drain("bp_drain");
    chk("bp_pops", 32'(npop - start), 32'd20);

    // Random interplay: 1000 random words with random gaps and random ready.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = npop;
    src_gap = 40;
    src_total = src_total + 1000;
    cyc = 0;
    while ((npop - start) < 1000 && cyc < 20000) begin
      bus.out_ready = 1'($urandom_range(1));
      tick();
      cyc++;
    end
    chk("rand_pops", 32'(npop - start), 32'd1000);
    chk("rand_pkt", 32'(pkt_cnt), 32'd62);
    chk("rand_beat", 32'(dut.beat_q), 32'd8);
    chk("rand_no_extra", 32'(bus.out_valid), 32'd0);
    src_gap = 0;

    // Flush with a word in flight: head and returning word are both dropped.
    bus.out_ready = 1'b1;
    preload(8'h80, 16);
    wait_valid("fl_first", 20);
    repeat (3) tick();
    pk = int'(pkt_cnt);
    flush = 1'b1;
    bus.out_ready = 1'b0;
    chk("fl_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_pre_inflight", 32'(dut.inflight_q), 32'd1);
    d = int'(bus.out_data);
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    wait_valid("fl_next", 20);
    chk("fl_next_data", 32'(bus.out_data), 32'((d + 2) & 8'hFF));
    chk("fl_beat", 32'(dut.beat_q), 32'd0);
    chk("fl_pkt_held", 32'(pkt_cnt), 32'(pk));
    // Flush with a full buffer.
    bus.out_ready = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl2_valid", 32'(bus.out_valid), 32'd0);
    chk("fl2_count", 32'(dut.u_skid.count_q), 32'd0);
    drain("fl_drain");

    // Reset in the middle of a packet.
    preload(8'hA0, 24);
    cyc = 0;
    while (!(bus.out_valid && mbeat == 5) && cyc < 100) begin tick(); cyc++; end
    chk("mr_beat5", 32'(dut.beat_q), 32'd5);
    rst_n = 1'b0;
    tick();
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_last", 32'(bus.out_last), 32'd0);
    chk("mr_data", 32'(bus.out_data), 32'd0);
    chk("mr_pkt", 32'(pkt_cnt), 32'd0);
    chk("mr_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("mr_count", 32'(dut.u_skid.count_q), 32'd0);
    chk("mr_beat", 32'(dut.beat_q), 32'd0);
    rst_n = 1'b1;
    wait_valid("mr_restart", 20);
    chk("mr_restart_beat", 32'(dut.beat_q), 32'd0);
    drain("mr_drain");

    chk("p1_activity", 32'(np2 > 20), 32'd1);
    done = 1'b1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
